branch_predict_unit: RTL and testbench

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/bp_pkg.sv | 22 ++
 rtl/branch_predict_unit_sat_ctr2.sv | 24 ++
 rtl/branch_predict_unit.sv | 126 ++++++++++++
 tb/tb_branch_predict_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: 2-bit counter encoding and table entry.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_e;

    // Tag is held zero-extended in a fixed 32-bit field so the struct stays
    // independent of the predictor parameters; only the low TAG_W bits are used.
    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [31:0] target;
        ctr_e        counter;
    } bp_entry_t;

    localparam bp_entry_t ENTRY_RST = '{valid: 1'b0, tag: 32'd0, target: 32'd0, counter: WNT};

endpackage

// File: rtl/branch_predict_unit_sat_ctr2.sv
// 2-bit saturating counter next-state: count up on taken, down on not-taken.
module sat_ctr2
    import bp_pkg::*;
(
    input  ctr_e ctr_i,
    input  logic taken_i,
    output ctr_e ctr_o
);

    logic [1:0] ctr_bits;

    assign ctr_bits = ctr_i;

    // Saturate at SNT and ST; otherwise step by one.
    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != ST) ctr_o = ctr_e'(ctr_bits + 2'd1);
        end else begin
            if (ctr_i != SNT) ctr_o = ctr_e'(ctr_bits - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped branch predictor with execute-stage resolution, redirect and statistics.
module branch_predict_unit
    import bp_pkg::*;
#(
    parameter int PC_W  = 9,
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [PC_W-1:0]  if_pc,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             ex_valid,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic [31:0]      ex_imm,
    input  logic [31:0]      ex_reg1,
    input  logic             ex_branch,
    input  logic             ex_jump,
    input  logic             ex_jalr,
    input  logic             ex_cond,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_target,
    output logic [31:0]      pc_four,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
);

    localparam int N_ENT = 2 ** IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    bp_entry_t        tbl_q [N_ENT];
    bp_entry_t        tbl_d [N_ENT];
    logic [CNT_W-1:0] stat_branches_q, stat_branches_d;
    logic [CNT_W-1:0] stat_mispredicts_q, stat_mispredicts_d;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [31:0]      if_tag, ex_tag;
    logic             if_hit, ex_hit;
    logic             ex_ctl, ex_taken, ex_branch_only;
    logic [31:0]      ex_target;
    ctr_e             ex_ctr_next;
    logic             unused_pc_lsbs;

    assign unused_pc_lsbs = &{1'b0, if_pc[1:0], ex_pc[1:0]};

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = 32'(if_pc[PC_W-1:IDX_W+2]);
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = 32'(ex_pc[PC_W-1:IDX_W+2]);

    // Fetch lookup reads the registered table only, so a same-cycle update is not bypassed.
    always_comb begin
        if_hit      = tbl_q[if_idx].valid && (tbl_q[if_idx].tag == if_tag);
        pred_taken  = if_hit && ((tbl_q[if_idx].counter == WT) || (tbl_q[if_idx].counter == ST));
        pred_target = pred_taken ? tbl_q[if_idx].target : (32'(if_pc) + 32'd4);
    end

    // Resolve the execute-stage control-flow instruction and decide on a redirect.
    always_comb begin
        ex_ctl         = ex_valid && (ex_branch || ex_jump || ex_jalr);
        ex_branch_only = ex_branch && !ex_jump && !ex_jalr;
        ex_taken       = ex_jalr || ex_jump || (ex_branch && ex_cond);
        ex_target      = ex_jalr ? ((ex_reg1 + ex_imm) & ~32'd1) : (32'(ex_pc) + ex_imm);
        pc_four        = 32'(ex_pc) + 32'd4;
        ex_hit         = tbl_q[ex_idx].valid && (tbl_q[ex_idx].tag == ex_tag);
        redirect       = ex_ctl && ((ex_taken != ex_pred_taken) ||
                                    (ex_taken && (ex_target != ex_pred_target)));
        redirect_pc    = ex_taken ? ex_target : pc_four;
    end

    sat_ctr2 u_sat_ctr2 (
        .ctr_i   (tbl_q[ex_idx].counter),
        .taken_i (ex_taken),
        .ctr_o   (ex_ctr_next)
    );

    // Train on a hit, allocate on a taken miss; a not-taken miss leaves the table alone.
    always_comb begin
        tbl_d = tbl_q;
        if (ex_ctl) begin
            if (ex_hit) begin
                tbl_d[ex_idx].counter = ex_ctr_next;
                if (ex_taken) tbl_d[ex_idx].target = ex_target;
            end else if (ex_taken) begin
                tbl_d[ex_idx] = '{valid: 1'b1, tag: ex_tag, target: ex_target,
                                  counter: (ex_branch_only ? WT : ST)};
            end
        end
    end

    // Saturating statistics; clear wins over a concurrent increment.
    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (stat_clr) begin
            stat_branches_d    = '0;
            stat_mispredicts_d = '0;
        end else begin
            if (ex_ctl && (stat_branches_q != CNT_MAX))
                stat_branches_d = stat_branches_q + 1'b1;
            if (redirect && (stat_mispredicts_q != CNT_MAX))
                stat_mispredicts_d = stat_mispredicts_q + 1'b1;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;

    // State registers; reset wipes everything the predictor has learned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_ENT; i++) tbl_q[i] <= ENTRY_RST;
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            tbl_q              <= tbl_d;
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit (PC_W=9, IDX_W=4, CNT_W=2).
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [8:0]  if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [8:0]  ex_pc;
    logic [31:0] ex_imm, ex_reg1;
    logic        ex_branch, ex_jump, ex_jalr, ex_cond, ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic [31:0] pc_four;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stat_clr;
    logic [1:0]  stat_branches, stat_mispredicts;

    int n_cmp = 0;
    int n_err = 0;

    branch_predict_unit #(.PC_W(9), .IDX_W(4), .CNT_W(2)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_imm           (ex_imm),
        .ex_reg1          (ex_reg1),
        .ex_branch        (ex_branch),
        .ex_jump          (ex_jump),
        .ex_jalr          (ex_jalr),
        .ex_cond          (ex_cond),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .pc_four          (pc_four),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .stat_clr         (stat_clr),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_idle();
        ex_valid = 0; ex_pc = '0; ex_imm = '0; ex_reg1 = '0;
        ex_branch = 0; ex_jump = 0; ex_jalr = 0; ex_cond = 0;
        ex_pred_taken = 0; ex_pred_target = '0;
    endtask

    task automatic ex_br(input logic [8:0] pc, input logic [31:0] imm, input logic cond,
                         input logic ptk, input logic [31:0] ptgt);
        ex_idle();
        ex_valid = 1; ex_branch = 1; ex_pc = pc; ex_imm = imm; ex_cond = cond;
        ex_pred_taken = ptk; ex_pred_target = ptgt;
    endtask

    initial begin
        ex_idle();
        stat_clr = 0;
        if_pc    = 9'h010;
        reset_n  = 0;
        #2;
        chk("rst_pred_taken", 32'(pred_taken), 32'd0);
        chk("rst_pred_target", pred_target, 32'h014);
        chk("rst_stat_b", 32'(stat_branches), 32'd0);
        chk("rst_stat_m", 32'(stat_mispredicts), 32'd0);
        #20 reset_n = 1;
        tick();
        chk("post_rst_pred_taken", 32'(pred_taken), 32'd0);
        chk("post_rst_pred_target", pred_target, 32'h014);

        // First taken branch at 0x020: mispredict, allocate WT
        ex_br(9'h020, 32'h40, 1, 0, 32'h0);
        if_pc = 9'h020;
        #1;
        chk("br_redirect", 32'(redirect), 32'd1);
        chk("br_redirect_pc", redirect_pc, 32'h060);
        chk("br_pc_four", pc_four, 32'h024);
        chk("br_no_bypass", 32'(pred_taken), 32'd0);
        tick();
        ex_idle();
        #1;
        chk("br_learned_taken", 32'(pred_taken), 32'd1);
        chk("br_learned_target", pred_target, 32'h060);
        chk("br_stat_b", 32'(stat_branches), 32'd1);
        chk("br_stat_m", 32'(stat_mispredicts), 32'd1);

        // Bubble: no redirect, no count
        ex_br(9'h020, 32'h40, 1, 0, 32'h0);
        ex_valid = 0;
        #1;
        chk("bubble_redirect", 32'(redirect), 32'd0);
        tick();
        chk("bubble_stat_b", 32'(stat_branches), 32'd1);

        // JALR target clears bit 0; jalr outranks branch
        ex_idle();
        ex_valid = 1; ex_jalr = 1; ex_pc = 9'h040; ex_reg1 = 32'h101; ex_imm = 32'h0;
        ex_pred_taken = 1; ex_pred_target = 32'h100;
        #1;
        chk("jalr_ok_redirect", 32'(redirect), 32'd0);
        ex_branch = 1; ex_cond = 0;
        #1;
        chk("jalr_prio_redirect", 32'(redirect), 32'd0);
        ex_pred_target = 32'h101;
        #1;
        chk("jalr_bad_redirect", 32'(redirect), 32'd1);
        chk("jalr_redirect_pc", redirect_pc, 32'h100);
        ex_idle();

        // Alias at 0x060: same index 8, different tag
        if_pc = 9'h060;
        #1;
        chk("alias_pred_taken", 32'(pred_taken), 32'd0);
        chk("alias_pred_target", pred_target, 32'h064);

        // Four correctly predicted taken branches (WT -> ST, saturates)
        if_pc = 9'h020;
        ex_br(9'h020, 32'h40, 1, 1, 32'h060);
        #1;
        chk("taken_ok_redirect", 32'(redirect), 32'd0);
        repeat (4) tick();
        chk("sat_stat_b", 32'(stat_branches), 32'd3);
        chk("four_ok_stat_m", 32'(stat_mispredicts), 32'd1);
        // Not-taken: ST -> WT, still taken
        ex_cond = 0;
        #1;
        chk("nt_redirect", 32'(redirect), 32'd1);
        chk("nt_redirect_pc", redirect_pc, 32'h024);
        tick();
        chk("after_one_nt_taken", 32'(pred_taken), 32'd1);
        chk("two_mis_stat_m", 32'(stat_mispredicts), 32'd2);
        // WT -> WNT
        tick();
        chk("wnt_pred_taken", 32'(pred_taken), 32'd0);
        chk("wnt_pred_target", pred_target, 32'h024);
        chk("three_mis_stat_m", 32'(stat_mispredicts), 32'd3);
        // WNT -> SNT, fourth mispredict saturates stat
        tick();
        chk("sat_stat_m", 32'(stat_mispredicts), 32'd3);
        // SNT stays SNT on not-taken
        ex_pred_taken = 0;
        tick();
        chk("snt_sat_pred_taken", 32'(pred_taken), 32'd0);

        // stat_clr beats a concurrent mispredict
        ex_br(9'h020, 32'h40, 1, 0, 32'h0);
        stat_clr = 1;
        #1;
        chk("clr_redirect", 32'(redirect), 32'd1);
        tick();
        stat_clr = 0;
        ex_idle();
        #1;
        chk("clr_stat_b", 32'(stat_branches), 32'd0);
        chk("clr_stat_m", 32'(stat_mispredicts), 32'd0);

        // JAL at 0x044 with negative offset allocates ST
        ex_idle();
        ex_valid = 1; ex_jump = 1; ex_pc = 9'h044; ex_imm = 32'hFFFF_FFF0;
        #1;
        chk("jal_redirect", 32'(redirect), 32'd1);
        chk("jal_redirect_pc", redirect_pc, 32'h034);
        tick();
        ex_idle();
        if_pc = 9'h044;
        #1;
        chk("jal_pred_taken", 32'(pred_taken), 32'd1);
        chk("jal_pred_target", pred_target, 32'h034);
        chk("jal_stat_b", 32'(stat_branches), 32'd1);
        chk("jal_stat_m", 32'(stat_mispredicts), 32'd1);

        // Not-taken miss does not allocate
        ex_br(9'h080, 32'h40, 0, 0, 32'h0);
        #1;
        chk("ntmiss_redirect", 32'(redirect), 32'd0);
        tick();
        ex_idle();
        if_pc = 9'h080;
        #1;
        chk("ntmiss_pred_taken", 32'(pred_taken), 32'd0);
        chk("ntmiss_pred_target", pred_target, 32'h084);

        // Asynchronous reset mid-run forgets everything
        if_pc = 9'h044;
        #1;
        reset_n = 0;
        #1;
        chk("midrst_pred_taken", 32'(pred_taken), 32'd0);
        chk("midrst_pred_target", pred_target, 32'h048);
        chk("midrst_stat_b", 32'(stat_branches), 32'd0);
        ex_valid = 1; ex_jump = 1; ex_pc = 9'h044; ex_imm = 32'hFFFF_FFF0;
        #1;
        chk("midrst_redirect", 32'(redirect), 32'd1);
        ex_idle();
        #1 reset_n = 1;
        tick();
        chk("postrst_044_miss", 32'(pred_taken), 32'd0);
        if_pc = 9'h020;
        #1;
        chk("postrst_020_miss", 32'(pred_taken), 32'd0);
        chk("postrst_020_target", pred_target, 32'h024);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
